// File: rtl/lane_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : lane_mem_responder_if                                    |
// | Brief   : Per-lane read/write request bundle for lane_mem_responder |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface lane_mem_responder_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int LANES     = 4
);
    logic [LANES-1:0]     mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address  [LANES];
    logic [LANES-1:0]     mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data     [LANES];
    logic [LANES-1:0]     mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address [LANES];
    logic [DATA_BITS-1:0] mem_write_data    [LANES];
    logic [LANES-1:0]     mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface
`default_nettype wire

// File: rtl/lane_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : lane_mem_responder                                       |
// | Brief   : Round-robin single-port data memory shared by LANES read  |
// |           and LANES write requesters; optional access counters      |
// |           enabled by macro LANE_MEM_PERF_COUNTERS_EN.               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module lane_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int LANES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lane_mem_responder_if.slave  bus,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count
);
    localparam int c_nreq      = 2 * LANES;
    localparam int c_ptr_bits  = (c_nreq > 1) ? $clog2(c_nreq) : 1;
    localparam int c_lane_bits = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                 r_state [c_nreq];
    logic [c_nreq-1:0]      r_ready;
    logic [c_ptr_bits-1:0]  r_rr_ptr;
    logic [DATA_BITS-1:0]   r_rd_data [LANES];
    logic [DATA_BITS-1:0]   r_mem [2**ADDR_BITS];

    logic [c_nreq-1:0]      w_valid;
    logic [c_nreq-1:0]      w_eligible;
    logic                   w_grant;
    logic [c_ptr_bits-1:0]  w_grant_idx;
    logic [c_ptr_bits-1:0]  w_next_ptr;
    logic                   w_grant_is_wr;
    logic [c_lane_bits-1:0] w_lane;
    logic [DATA_BITS-1:0]   w_rd_word;

    // Requester i is lane i read, requester LANES+i is lane i write.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_valid[l]             = bus.mem_read_valid[l];
        assign w_valid[LANES+l]       = bus.mem_write_valid[l];
        assign bus.mem_read_ready[l]  = r_ready[l];
        assign bus.mem_write_ready[l] = r_ready[LANES+l];
        assign bus.mem_read_data[l]   = r_rd_data[l];
    end

    for (genvar i = 0; i < c_nreq; i++) begin : g_req
        assign w_eligible[i] = (r_state[i] == ST_IDLE) && w_valid[i];
    end

    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < c_nreq; k++) begin
            if (!w_grant && w_eligible[c_ptr_bits'((int'(r_rr_ptr) + k) % c_nreq)]) begin
                w_grant     = 1'b1;
                w_grant_idx = c_ptr_bits'((int'(r_rr_ptr) + k) % c_nreq);
            end
        end
    end

    always_comb begin
        w_next_ptr    = (int'(w_grant_idx) == c_nreq - 1) ? '0 : w_grant_idx + 1'b1;
        w_grant_is_wr = (int'(w_grant_idx) >= LANES);
        w_lane        = w_grant_is_wr ? c_lane_bits'(int'(w_grant_idx) - LANES)
                                      : c_lane_bits'(w_grant_idx);
    end

    assign w_rd_word = r_mem[bus.mem_read_address[w_lane]];

    // Memory has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && w_grant && w_grant_is_wr) begin
            r_mem[bus.mem_write_address[w_lane]] <= bus.mem_write_data[w_lane];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_ready  <= '0;
            for (int i = 0; i < c_nreq; i++) begin
                r_state[i] <= ST_IDLE;
            end
            for (int l = 0; l < LANES; l++) begin
                r_rd_data[l] <= '0;
            end
        end else begin
            // A dropped valid releases the requester without making it eligible this edge.
            for (int i = 0; i < c_nreq; i++) begin
                if (r_state[i] == ST_ACK && !w_valid[i]) begin
                    r_state[i] <= ST_IDLE;
                    r_ready[i] <= 1'b0;
                end
            end
            if (w_grant) begin
                r_rr_ptr             <= w_next_ptr;
                r_state[w_grant_idx] <= ST_ACK;
                r_ready[w_grant_idx] <= 1'b1;
                if (!w_grant_is_wr) begin
                    r_rd_data[w_lane] <= w_rd_word;
                end
            end
        end
    end

`ifdef LANE_MEM_PERF_COUNTERS_EN
    logic [15:0] r_read_count;
    logic [15:0] r_write_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_count  <= '0;
            r_write_count <= '0;
        end else if (w_grant) begin
            if (!w_grant_is_wr && r_read_count != 16'hFFFF) begin
                r_read_count <= r_read_count + 16'd1;
            end
            if (w_grant_is_wr && r_write_count != 16'hFFFF) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_lane_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_lane_mem_responder                                    |
// | Brief   : Self-checking bench: vector table, directed sequences and |
// |           random traffic against a behavioural model.               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_lane_mem_responder;
    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 32;
    localparam int LANES     = 4;
    localparam int NREQ      = 2 * LANES;
`ifdef LANE_MEM_PERF_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] read_count;
    logic [15:0] write_count;

    lane_mem_responder_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LANES(LANES)) bus ();

    lane_mem_responder #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LANES(LANES)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .read_count  (read_count),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int                   m_ptr;
    bit                   m_ack   [NREQ];
    logic [DATA_BITS-1:0] m_mem   [2**ADDR_BITS];
    logic [DATA_BITS-1:0] m_rdata [LANES];
    int                   m_rc;
    int                   m_wc;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] wv;
        logic [3:0] exp_rr;
        logic [3:0] exp_wr;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0;
        m_rc  = 0;
        m_wc  = 0;
        for (int i = 0; i < NREQ; i++) m_ack[i] = 1'b0;
        for (int l = 0; l < LANES; l++) m_rdata[l] = '0;
    endfunction

    function automatic void model_edge();
        bit v [NREQ];
        int g;
        g = -1;
        for (int l = 0; l < LANES; l++) begin
            v[l]       = bus.mem_read_valid[l];
            v[LANES+l] = bus.mem_write_valid[l];
        end
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && !m_ack[(m_ptr + k) % NREQ] && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (m_ack[i] && !v[i]) m_ack[i] = 1'b0;
        end
        if (g >= 0) begin
            m_ack[g] = 1'b1;
            m_ptr    = (g + 1) % NREQ;
            if (g < LANES) begin
                m_rdata[g] = m_mem[bus.mem_read_address[g]];
                if (CNT_EN && m_rc < 65535) m_rc++;
            end else begin
                m_mem[bus.mem_write_address[g-LANES]] = bus.mem_write_data[g-LANES];
                if (CNT_EN && m_wc < 65535) m_wc++;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [LANES-1:0] er;
        logic [LANES-1:0] ew;
        for (int l = 0; l < LANES; l++) begin
            er[l] = m_ack[l];
            ew[l] = m_ack[LANES+l];
        end
        chk({tag, ".read_ready"},  64'(bus.mem_read_ready),  64'(er));
        chk({tag, ".write_ready"}, 64'(bus.mem_write_ready), 64'(ew));
        for (int l = 0; l < LANES; l++) begin
            chk($sformatf("%s.read_data[%0d]", tag, l), 64'(bus.mem_read_data[l]), 64'(m_rdata[l]));
        end
        chk({tag, ".read_count"},  64'(read_count),  64'(m_rc));
        chk({tag, ".write_count"}, 64'(write_count), 64'(m_wc));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic clear_inputs();
        bus.mem_read_valid  = '0;
        bus.mem_write_valid = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.mem_read_address[l]  = '0;
            bus.mem_write_address[l] = '0;
            bus.mem_write_data[l]    = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("reset_async");
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_BITS-1:0] d_exp;
        int rc0;

        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Preload addresses 0..63 through lane 3 writes.
        for (int a = 0; a < 64; a++) begin
            bus.mem_write_valid[3]   = 1'b1;
            bus.mem_write_address[3] = 8'(a);
            bus.mem_write_data[3]    = $urandom;
            step("preload_grant");
            bus.mem_write_valid[3] = 1'b0;
            step("preload_drop");
        end

        // Lane 0 write 0x10, drop, then read it back.
        do_reset();
        bus.mem_write_valid[0]   = 1'b1;
        bus.mem_write_address[0] = 8'h10;
        bus.mem_write_data[0]    = 32'h0001_8000;
        step("wr10");
        chk("wr10.write_ready", 64'(bus.mem_write_ready), 64'h1);
        bus.mem_write_valid[0] = 1'b0;
        step("wr10_drop");
        chk("wr10_drop.write_ready", 64'(bus.mem_write_ready), 64'h0);
        bus.mem_read_valid[0]   = 1'b1;
        bus.mem_read_address[0] = 8'h10;
        step("rd10");
        chk("rd10.read_ready", 64'(bus.mem_read_ready), 64'h1);
        chk("rd10.read_data", 64'(bus.mem_read_data[0]), 64'h0001_8000);
        bus.mem_read_valid[0] = 1'b0;
        step("rd10_drop");

        // Lane 2 holds valid for 5 cycles after ready.
        rc0 = m_rc;
        bus.mem_read_valid[2]   = 1'b1;
        bus.mem_read_address[2] = 8'h10;
        step("hold_grant");
        chk("hold_grant.ready2", 64'(bus.mem_read_ready[2]), 64'h1);
        for (int c = 0; c < 5; c++) begin
            step("hold");
            chk("hold.ready2", 64'(bus.mem_read_ready[2]), 64'h1);
            chk("hold.data2", 64'(bus.mem_read_data[2]), 64'h0001_8000);
        end
        chk("hold.read_count", 64'(read_count), CNT_EN ? 64'(rc0 + 1) : 64'h0);
        bus.mem_read_valid[2] = 1'b0;
        step("hold_drop");
        chk("hold_drop.ready2", 64'(bus.mem_read_ready[2]), 64'h0);

        // Vector table: four simultaneous reads, then round-robin with writes.
        tbl[0] = '{4'hF, 4'h0, 4'h1, 4'h0};
        tbl[1] = '{4'hF, 4'h0, 4'h3, 4'h0};
        tbl[2] = '{4'hF, 4'h0, 4'h7, 4'h0};
        tbl[3] = '{4'hF, 4'h0, 4'hF, 4'h0};
        tbl[4] = '{4'h0, 4'h0, 4'h0, 4'h0};
        tbl[5] = '{4'h0, 4'h1, 4'h0, 4'h1};
        tbl[6] = '{4'h0, 4'h0, 4'h0, 4'h0};
        tbl[7] = '{4'h2, 4'h2, 4'h0, 4'h2};
        tbl[8] = '{4'h2, 4'h2, 4'h2, 4'h2};
        tbl[9] = '{4'h0, 4'h0, 4'h0, 4'h0};
        do_reset();
        for (int l = 0; l < LANES; l++) begin
            bus.mem_read_address[l]  = 8'(l + 1);
            bus.mem_write_address[l] = 8'(8 + l);
            bus.mem_write_data[l]    = $urandom;
        end
        for (int i = 0; i < 10; i++) begin
            bus.mem_read_valid  = tbl[i].rv;
            bus.mem_write_valid = tbl[i].wv;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.rr", i), 64'(bus.mem_read_ready),  64'(tbl[i].exp_rr));
            chk($sformatf("tbl%0d.wr", i), 64'(bus.mem_write_ready), 64'(tbl[i].exp_wr));
        end

        // Reset while lanes 1 and 3 sit in ACK with valid held.
        do_reset();
        clear_inputs();
        bus.mem_read_valid      = 4'b1010;
        bus.mem_read_address[1] = 8'h10;
        bus.mem_read_address[3] = 8'h20;
        step("ack13_a");
        chk("ack13_a.rr", 64'(bus.mem_read_ready), 64'h2);
        step("ack13_b");
        chk("ack13_b.rr", 64'(bus.mem_read_ready), 64'hA);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_mid.rr", 64'(bus.mem_read_ready), 64'h0);
        chk("rst_mid.data1", 64'(bus.mem_read_data[1]), 64'h0);
        chk("rst_mid.data3", 64'(bus.mem_read_data[3]), 64'h0);
        @(posedge clk);
        #1;
        check_outputs("rst_mid_hold");
        @(negedge clk);
        reset = 1'b0;
        step("reserve_a");
        chk("reserve_a.rr", 64'(bus.mem_read_ready), 64'h2);
        step("reserve_b");
        chk("reserve_b.rr", 64'(bus.mem_read_ready), 64'hA);
        bus.mem_read_valid = '0;
        step("reserve_drop");

        // Lane 1 read and write to the same address together.
        bus.mem_write_valid[0]   = 1'b1;
        bus.mem_write_address[0] = 8'h20;
        bus.mem_write_data[0]    = 32'h0000_AAAA;
        step("old_wr");
        bus.mem_write_valid[0] = 1'b0;
        step("old_wr_drop");
        do_reset();
        bus.mem_read_address[1]  = 8'h20;
        bus.mem_write_address[1] = 8'h20;
        bus.mem_write_data[1]    = 32'h0000_5555;
        bus.mem_read_valid[1]    = 1'b1;
        bus.mem_write_valid[1]   = 1'b1;
        step("rw_a");
        chk("rw_a.rr", 64'(bus.mem_read_ready), 64'h2);
        chk("rw_a.wr", 64'(bus.mem_write_ready), 64'h0);
        chk("rw_a.data1", 64'(bus.mem_read_data[1]), 64'h0000_AAAA);
        step("rw_b");
        chk("rw_b.wr", 64'(bus.mem_write_ready), 64'h2);
        bus.mem_read_valid[1]  = 1'b0;
        bus.mem_write_valid[1] = 1'b0;
        step("rw_drop");
        bus.mem_read_valid[2]   = 1'b1;
        bus.mem_read_address[2] = 8'h20;
        step("rw_check");
        chk("rw_check.data2", 64'(bus.mem_read_data[2]), 64'h0000_5555);
        bus.mem_read_valid[2] = 1'b0;
        step("rw_check_drop");

        // Random traffic including withdrawn requests.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic cur;
                cur = (i < LANES) ? bus.mem_read_valid[i] : bus.mem_write_valid[i-LANES];
                if (m_ack[i]) begin
                    if ($urandom_range(0, 9) < 4) cur = 1'b0;
                end else if (cur) begin
                    if ($urandom_range(0, 9) == 0) cur = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    cur = 1'b1;
                    if (i < LANES) begin
                        bus.mem_read_address[i] = 8'($urandom_range(0, 15));
                    end else begin
                        bus.mem_write_address[i-LANES] = 8'($urandom_range(0, 15));
                        bus.mem_write_data[i-LANES]    = $urandom;
                    end
                end
                if (i < LANES) bus.mem_read_valid[i] = cur;
                else           bus.mem_write_valid[i-LANES] = cur;
            end
            step("rand");
        end

        clear_inputs();
        step("final");
        d_exp = CNT_EN ? 32'(m_rc) : 32'h0;
        chk("final.read_count", 64'(read_count), 64'(d_exp));
        d_exp = CNT_EN ? 32'(m_wc) : 32'h0;
        chk("final.write_count", 64'(write_count), 64'(d_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
